// File: rtl/seg_disp_pkg.sv
// ---------------------------------------------------------------------------
// seg_disp_pkg
//   Shared constants for the dual-channel hex display:
//     NUM_DIGITS  - number of scanned digits on the board
//     SEG_BLANK   - active-low segment pattern with every segment off
//     AN_OFF      - active-low anode pattern with every digit off
//     HEX_SEG     - hex-to-segment table, bit order {g,f,e,d,c,b,a},
//                   active-low (0 lights the segment)
// ---------------------------------------------------------------------------
package seg_disp_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex_to_7seg.sv
// ---------------------------------------------------------------------------
// hex_to_7seg
//   Purely combinational 4-bit to 7-segment decoder (active-low outputs).
//   Ports:
//     nibble_i  [3:0]  hex value to show
//     seg_o     [6:0]  segments {g,f,e,d,c,b,a}, 0 = lit
// ---------------------------------------------------------------------------
module hex_to_7seg
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/demux_dual_hex_display.sv
// ---------------------------------------------------------------------------
// demux_dual_hex_display
//   Captures the two 16-bit outputs of the upstream 1-to-2 demux into holding
//   registers and scans them onto an 8-digit common-anode 7-segment display.
//   Channel A occupies digits 7..4, channel B digits 3..0.
//
//   Parameters:
//     SIZE        - channel width, fixed at 16 (4 hex digits per channel)
//     REFRESH_DIV - clock cycles each digit stays active (>= 1)
//
//   Ports:
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     in_a   in   demux output A
//     in_b   in   demux output B
//     sel    in   demux select: 0 = capture A, 1 = capture B
//     cap    in   capture strobe, sampled every clock
//     an     out  digit enables, active-low, an[0] = rightmost digit
//     seg    out  segments {g,f,e,d,c,b,a}, active-low
//     dp     out  decimal point, active-low, held off
//
//   Build option:
//     LEAD_ZERO_BLANK_EN - when defined, zero nibbles above the most
//                          significant nonzero nibble of each channel are
//                          blanked; the lowest digit of each channel always
//                          shows. The anode scan and latency are unaffected.
// ---------------------------------------------------------------------------
module demux_dual_hex_display
    import seg_disp_pkg::*;
#(
    parameter int SIZE        = 16,
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    input  logic            sel,
    input  logic            cap,
    output logic [7:0]      an,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam int            PW       = $clog2(REFRESH_DIV + 1);
    localparam int            IW       = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] DIV_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [SIZE-1:0] reg_a_q;
    logic [SIZE-1:0] reg_b_q;
    logic [PW-1:0]   presc_q;
    logic [PW-1:0]   presc_d;
    logic [IW-1:0]   digit_idx_q;
    logic [IW-1:0]   digit_idx_d;
    logic [7:0]      an_q;
    logic [7:0]      an_d;
    logic [6:0]      seg_q;
    logic [6:0]      seg_d;

    logic [SIZE-1:0] chan_val;
    logic [1:0]      nib_pos;
    logic [3:0]      nibble;
    logic [6:0]      dec_seg;
    logic            blank;

    // ------------------------------------------------------------------
    // Capture registers: only the register matching sel is written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
        end else if (cap) begin
            if (sel) begin
                reg_b_q <= in_b;
            end else begin
                reg_a_q <= in_a;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and digit counter. The digit advances on the cycle the
    // prescaler wraps; with REFRESH_DIV = 1 the prescaler sits at 0 and
    // the wrap condition is true every cycle.
    // ------------------------------------------------------------------
    always_comb begin
        presc_d     = presc_q + PW'(1);
        digit_idx_d = digit_idx_q;
        if (presc_q == DIV_LAST) begin
            presc_d = '0;
            if (digit_idx_q == IDX_LAST) begin
                digit_idx_d = '0;
            end else begin
                digit_idx_d = digit_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            digit_idx_q <= '0;
        end else begin
            presc_q     <= presc_d;
            digit_idx_q <= digit_idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Nibble selection: the top index bit picks the channel (1 = A),
    // the low two bits pick the nibble within it.
    // ------------------------------------------------------------------
    assign chan_val = digit_idx_q[IW-1] ? reg_a_q : reg_b_q;
    assign nib_pos  = digit_idx_q[1:0];

    always_comb begin
        nibble = chan_val[3:0];
        case (nib_pos)
            2'd0: nibble = chan_val[3:0];
            2'd1: nibble = chan_val[7:4];
            2'd2: nibble = chan_val[11:8];
            2'd3: nibble = chan_val[15:12];
            default: nibble = chan_val[3:0];
        endcase
    end

    hex_to_7seg u_hex_to_7seg (
        .nibble_i (nibble),
        .seg_o    (dec_seg)
    );

`ifdef LEAD_ZERO_BLANK_EN
    // A nibble is a leading zero when it and every nibble above it in the
    // same channel are zero. Position 0 is never blanked so zero shows "0".
    always_comb begin
        blank = 1'b0;
        case (nib_pos)
            2'd0: blank = 1'b0;
            2'd1: blank = ~|chan_val[15:4];
            2'd2: blank = ~|chan_val[15:8];
            2'd3: blank = ~|chan_val[15:12];
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Output register: one cycle behind digit_idx and capture registers.
    // ------------------------------------------------------------------
    assign an_d  = ~(8'b1 << digit_idx_q);
    assign seg_d = blank ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: doc/demux_dual_hex_display.md
Name: demux_dual_hex_display

Overview:
- Downstream consumer of the 1-to-2 demux stage.
- Captures the demux's two 16-bit output channels (A and B) into holding registers when the matching select is presented with a capture strobe.
- Time-multiplexes both channels as 8 hex digits on the board's common-anode 7-segment display: A on digits 7..4, B on digits 3..0.

Parameters:
- SIZE, 16, channel width; fixed at 16 (4 hex digits per channel). Other values unsupported.
- REFRESH_DIV, 100000, clock cycles per digit slot; legal range >= 1. 100000 gives 1 kHz per digit at 100 MHz.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_a  input  16  demux outputA.
- in_b  input  16  demux outputB.
- sel  input  1  same select driving the demux; 0 = channel A, 1 = channel B.
- cap  input  1  capture strobe, sampled each clock.
- an  output  8  digit enables, active-low; an[0] is the rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; always 1 (off).

Behaviour:
- Reset (async assert, sync release by clock):
  - reg_a = 0, reg_b = 0.
  - prescaler = 0, digit_idx = 0.
  - an = 8'hFF, seg = 7'h7F, dp = 1.
- Capture:
  - On a rising edge with cap=1: sel=0 loads reg_a <= in_a; sel=1 loads reg_b <= in_b. The other register holds.
  - cap=0: both registers hold.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV+1).
  - At REFRESH_DIV-1 it wraps to 0 and digit_idx increments mod 8 (7 -> 0).
  - REFRESH_DIV=1: digit_idx advances every cycle.
- Output register (updated every cycle from current digit_idx and capture registers):
  - an <= ~(8'b1 << digit_idx).
  - seg <= hex decode of the selected nibble.
  - Nibble map: idx 0..3 = reg_b[3:0], [7:4], [11:8], [15:12]; idx 4..7 = reg_a[3:0], [7:4], [11:8], [15:12].
- Latency:
  - Outputs lag digit_idx and register contents by exactly 1 cycle.
  - A capture at edge N is visible on seg at edge N+1 if that digit is active.
  - First edge after reset release gives an = 8'hFE.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Simultaneous events:
  - Capture and prescaler wrap on the same edge are independent; both take effect.
  - Capture during the active slot of the changed digit shows the new nibble one cycle later, with no glitch beyond that.
- Reset mid-scan: all state returns to reset values immediately, without waiting for a clock edge. Captured data is lost.
- Exactly one an bit is low at any time after the first post-reset edge.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined:
  - Within each channel independently, zero nibbles above that channel's most-significant nonzero nibble drive seg = 7'h7F (blank). The an scan is unchanged.
  - Digit 0 of each channel (idx 0 and idx 4) is never blanked, so a value of 0 shows "0".
  - Example: reg_a = 0x0040 blanks idx 7 and 6; shows "4" on idx 5 and "0" on idx 4.
- Undefined: all 8 digits always display, including leading zeros.
- Latency is identical in both builds.

Decomposition:
- Package seg_disp_pkg holds:
  - NUM_DIGITS = 8
  - SEG_BLANK = 7'h7F
  - AN_OFF = 8'hFF
  - the 16-entry hex-to-segment constant table
- Sub-module hex_to_7seg: purely combinational 4-bit to 7-bit decoder using the package table, one instance.
- Top module holds capture registers, prescaler, digit counter, blanking logic and output registers.

Test Plan:
- Reset check: hold rst_n=0 -> an=FF, seg=7F, dp=1. Release with REFRESH_DIV=4 -> next edge an=FE, seg=1000000 (reg_b=0).
- Capture and scan: cap=1, sel=0, in_a=0x1234; then cap=1, sel=1, in_b=0xABCD; REFRESH_DIV=4 -> over 32 cycles an walks FE, FD, ... 7F, 4 cycles each. seg sequence: D, C, b, A, 4, 3, 2, 1. Then wraps to FE.
- Capture gating: cap=0 with in_a=0xFFFF, sel=0 -> display unchanged. cap=1, sel=1 -> only reg_b changes; reg_a digits unchanged.
- Mid-scan reset: assert rst_n=0 at digit_idx=5 between edges -> an=FF, seg=7F immediately. After release, scan restarts at idx 0 and all digits show 0.
- REFRESH_DIV=1: an changes every cycle, FE -> FD -> ... -> 7F -> FE. Capture in the same cycle as a wrap shows the new value at the next visit.
- LEAD_ZERO_BLANK_EN build: reg_a=0x0040, reg_b=0x0000 -> idx 7 and 6 show 7F, idx 5 shows 4, idx 4 shows 0, idx 3..1 show 7F, idx 0 shows 0.
